cacheline_adaptor: RTL and testbench

Memory-side responder for the cache line-fill interface. It accepts a whole-line read (and optionally write) request from a cache controller, runs it as a fixed-length burst on the physical-memory port, and returns a one-cycle completion pulse. It sits between a cache controller (I-cache demand and prefetch fills, or a D-cache) and main memory.

---
 rtl/cacheline_pkg.sv | 22 ++
 rtl/cacheline_adaptor.sv | 124 ++++++++++++
 tb/tb_cacheline_adaptor.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_pkg.sv
// Shared types and constants for the cache line-fill adaptor.
// Optional write path is enabled by defining CACHELINE_WRITE_EN.
package cacheline_pkg;

  localparam int CL_LINE_W  = 256;
  localparam int CL_BURST_W = 64;
  localparam int CL_ADDR_W  = 32;

  localparam int BEATS = CL_LINE_W / CL_BURST_W;

  typedef logic [CL_LINE_W-1:0]  line_t;
  typedef logic [CL_BURST_W-1:0] burst_t;
  typedef logic [CL_ADDR_W-1:0]  addr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Whole-line request to fixed-length memory burst adaptor with one-cycle completion pulse.
// Write path (WRITE state, line_i latch, burst_o) exists only when CACHELINE_WRITE_EN is defined.
module cacheline_adaptor
  import cacheline_pkg::*;
#(
  parameter int LINE_W  = CL_LINE_W,
  parameter int BURST_W = CL_BURST_W,
  parameter int ADDR_W  = CL_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   address_i,
  input  logic                read_i,
  input  logic                write_i,
  input  logic [LINE_W-1:0]   line_i,
  output logic [LINE_W-1:0]   line_o,
  output logic                resp_o,
  output logic [ADDR_W-1:0]   address_o,
  output logic                read_o,
  output logic                write_o,
  output logic [BURST_W-1:0]  burst_o,
  input  logic [BURST_W-1:0]  burst_i,
  input  logic                resp_i,
  output adaptor_state_t      state_dbg
);

  localparam int N_BEATS = LINE_W / BURST_W;
  localparam int CW      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int OFF     = $clog2(LINE_W / 8);
  localparam logic [CW-1:0]     LAST     = CW'(N_BEATS - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF) - 64'd1);

  // Handshake: the cache holds read_i/write_i (and its data) high until the
  // single-cycle resp_o; memory moves exactly one beat per cycle with resp_i
  // high while read_o/write_o is asserted, and resp_i elsewhere is ignored.

  adaptor_state_t state_q, state_d;
  logic [CW-1:0]     count_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] rbuf_q, rbuf_d, line_q;
  logic              last_beat;

  always_comb begin
    state_d   = state_q;
    rbuf_d    = rbuf_q;
    rbuf_d[int'(count_q) * BURST_W +: BURST_W] = burst_i;
    last_beat = resp_i && (count_q == LAST);
    case (state_q)
      ST_IDLE: begin
`ifdef CACHELINE_WRITE_EN
        if (write_i)
          state_d = ST_WRITE;
        else if (read_i)
          state_d = ST_READ;
`else
        if (read_i)
          state_d = ST_READ;
`endif
      end
      ST_READ: begin
        if (last_beat)
          state_d = ST_DONE;
      end
      ST_WRITE: begin
`ifdef CACHELINE_WRITE_EN
        if (last_beat)
          state_d = ST_DONE;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      addr_q  <= '0;
      rbuf_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && state_d != ST_IDLE) begin
        addr_q  <= address_i & ~OFF_MASK;
        count_q <= '0;
      end else if ((state_q == ST_READ || state_q == ST_WRITE) && resp_i) begin
        count_q <= count_q + CW'(1);
      end
      if (state_q == ST_READ && resp_i)
        rbuf_q <= rbuf_d;
      // line_o only changes when a read fill completes, so writes leave it alone.
      if (state_q == ST_READ && last_beat)
        line_q <= rbuf_d;
    end
  end

  assign read_o    = (state_q == ST_READ);
  assign resp_o    = (state_q == ST_DONE);
  assign address_o = addr_q;
  assign line_o    = line_q;
  assign state_dbg = state_q;

`ifdef CACHELINE_WRITE_EN
  logic [LINE_W-1:0] wdata_q;

  always_ff @(posedge clk) begin
    if (rst)
      wdata_q <= '0;
    else if (state_q == ST_IDLE && write_i)
      wdata_q <= line_i;
  end

  assign write_o = (state_q == ST_WRITE);
  assign burst_o = write_o ? wdata_q[int'(count_q) * BURST_W +: BURST_W] : '0;
`else
  logic unused_write_inputs;
  assign unused_write_inputs = ^{write_i, line_i};
  assign write_o = 1'b0;
  assign burst_o = '0;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed and randomized checks of cacheline_adaptor against a line-level memory/cache model.
// Write-path checks are built only when CACHELINE_WRITE_EN is defined.
module tb_cacheline_adaptor;
  import cacheline_pkg::*;

  localparam int LW = 256;
  localparam int BW = 64;
  localparam int AW = 32;
  localparam int NB = LW / BW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] address_i;
  logic          read_i, write_i;
  logic [LW-1:0] line_i, line_o;
  logic          resp_o;
  logic [AW-1:0] address_o;
  logic          read_o, write_o;
  logic [BW-1:0] burst_o, burst_i;
  logic          resp_i;
  adaptor_state_t state_dbg;

  int vectors     = 0;
  int miscompares = 0;
  logic [LW-1:0] last_line;

  cacheline_adaptor dut (
    .clk(clk), .rst(rst),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .line_i(line_i),
    .line_o(line_o), .resp_o(resp_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o),
    .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] d;
    for (int i = 0; i < LW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [AW-1:0] line_base(input logic [AW-1:0] a);
    return a - (a % AW'(LW / 8));
  endfunction

  function automatic logic [4*NB-1:0] rand_gaps();
    logic [4*NB-1:0] g;
    for (int k = 0; k < NB; k++) g[k*4 +: 4] = 4'($urandom_range(0, 2));
    return g;
  endfunction

  // One whole-line read: request cycle, beats with gaps[k] idle cycles before beat k, DONE cycle.
  task automatic do_read(input logic [AW-1:0] addr, input logic [LW-1:0] data,
                         input logic [4*NB-1:0] gaps, input logic both);
    logic [AW-1:0] exp_addr;
    exp_addr = line_base(addr);
    @(posedge clk); #1;
    address_i = addr; read_i = 1'b1; write_i = both; resp_i = 1'b0; burst_i = {$urandom, $urandom};
    @(negedge clk);
    chk("rd_req_read_o", LW'(read_o), LW'(1'b0));
    chk("rd_req_resp_o", LW'(resp_o), LW'(1'b0));
    for (int k = 0; k < NB; k++) begin
      for (int g = 0; g < int'(gaps[k*4 +: 4]); g++) begin
        @(posedge clk); #1;
        resp_i = 1'b0; burst_i = {$urandom, $urandom}; address_i = $urandom;
        @(negedge clk);
        chk("rd_gap_read_o", LW'(read_o), LW'(1'b1));
        chk("rd_gap_resp_o", LW'(resp_o), LW'(1'b0));
      end
      @(posedge clk); #1;
      resp_i = 1'b1; burst_i = data[k*BW +: BW]; address_i = $urandom;
      @(negedge clk);
      chk("rd_beat_read_o", LW'(read_o), LW'(1'b1));
      chk("rd_beat_addr", LW'(address_o), LW'(exp_addr));
      chk("rd_beat_write_o", LW'(write_o), LW'(1'b0));
    end
    @(posedge clk); #1;
    resp_i = 1'b0; burst_i = {$urandom, $urandom};
    @(negedge clk);
    chk("rd_done_resp_o", LW'(resp_o), LW'(1'b1));
    chk("rd_done_line", line_o, data);
    chk("rd_done_read_o", LW'(read_o), LW'(1'b0));
    last_line = data;
  endtask

  task automatic idle(input int n, input logic noise);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      read_i = 1'b0; write_i = 1'b0; address_i = $urandom;
      resp_i = noise ? 1'($urandom_range(0, 1)) : 1'b0; burst_i = {$urandom, $urandom};
      @(negedge clk);
      chk("idle_resp_o", LW'(resp_o), LW'(1'b0));
      chk("idle_read_o", LW'(read_o), LW'(1'b0));
      chk("idle_write_o", LW'(write_o), LW'(1'b0));
      chk("idle_line", line_o, last_line);
    end
  endtask

`ifdef CACHELINE_WRITE_EN
  task automatic do_write(input logic [AW-1:0] addr, input logic [LW-1:0] data,
                          input logic [4*NB-1:0] gaps, input logic both);
    logic [AW-1:0] exp_addr;
    exp_addr = line_base(addr);
    @(posedge clk); #1;
    address_i = addr; write_i = 1'b1; read_i = both; line_i = data; resp_i = 1'b0;
    @(negedge clk);
    chk("wr_req_write_o", LW'(write_o), LW'(1'b0));
    for (int k = 0; k < NB; k++) begin
      for (int g = 0; g < int'(gaps[k*4 +: 4]); g++) begin
        @(posedge clk); #1;
        resp_i = 1'b0; line_i = rand_line(); address_i = $urandom;
        @(negedge clk);
        chk("wr_gap_write_o", LW'(write_o), LW'(1'b1));
        chk("wr_gap_burst", LW'(burst_o), LW'(data[k*BW +: BW]));
      end
      @(posedge clk); #1;
      resp_i = 1'b1; line_i = rand_line(); address_i = $urandom;
      @(negedge clk);
      chk("wr_beat_write_o", LW'(write_o), LW'(1'b1));
      chk("wr_beat_read_o", LW'(read_o), LW'(1'b0));
      chk("wr_beat_burst", LW'(burst_o), LW'(data[k*BW +: BW]));
      chk("wr_beat_addr", LW'(address_o), LW'(exp_addr));
    end
    @(posedge clk); #1;
    resp_i = 1'b0;
    @(negedge clk);
    chk("wr_done_resp_o", LW'(resp_o), LW'(1'b1));
    chk("wr_done_write_o", LW'(write_o), LW'(1'b0));
    chk("wr_done_line", line_o, last_line);
  endtask
`endif

  initial begin
    logic [LW-1:0] d;
    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = '0; line_i = '0; burst_i = '0;
    last_line = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_read_o", LW'(read_o), LW'(1'b0));
    chk("rst_write_o", LW'(write_o), LW'(1'b0));
    chk("rst_resp_o", LW'(resp_o), LW'(1'b0));
    chk("rst_addr", LW'(address_o), '0);
    chk("rst_burst", LW'(burst_o), '0);
    chk("rst_line", line_o, '0);

    // Consecutive-beat read at an unaligned address.
    d = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_read(32'h0000_1234, d, '0, 1'b0);
    chk("t1_addr_aligned", LW'(address_o), LW'(32'h0000_1220));
    idle(2, 1'b0);

    // Read with resp_i pattern 1,0,0,1,1,0,1.
    do_read(32'h0000_8040, rand_line(), {4'd1, 4'd0, 4'd2, 4'd0}, 1'b0);
    idle(1, 1'b0);

    // resp_i noise while idle must be ignored.
    idle(6, 1'b1);

`ifdef CACHELINE_WRITE_EN
    do_write(32'h0000_2000, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                             64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, '0, 1'b0);
    idle(1, 1'b0);
    // Simultaneous request: write first, then the read that stayed asserted.
    do_write(32'h0000_3010, rand_line(), rand_gaps(), 1'b1);
    do_read(32'h0000_3010, rand_line(), rand_gaps(), 1'b0);
    idle(3, 1'b0);
`else
    // Simultaneous request on a read-only build behaves as a single read.
    do_read(32'h0000_3010, rand_line(), rand_gaps(), 1'b1);
    idle(4, 1'b0);
`endif

    // Reset after the second beat abandons the burst.
    @(posedge clk); #1;
    address_i = 32'h0000_4000; read_i = 1'b1; resp_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      resp_i = 1'b1; burst_i = {$urandom, $urandom};
    end
    @(posedge clk); #1;
    rst = 1'b1; resp_i = 1'b0; read_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    last_line = '0;
    chk("mid_rst_read_o", LW'(read_o), LW'(1'b0));
    chk("mid_rst_resp_o", LW'(resp_o), LW'(1'b0));
    chk("mid_rst_line", line_o, '0);
    chk("mid_rst_addr", LW'(address_o), '0);
    do_read(32'h0000_4008, rand_line(), '0, 1'b0);

    // Back-to-back reads without an idle gap, then randomized traffic.
    do_read($urandom, rand_line(), rand_gaps(), 1'b0);
    idle(1, 1'b1);
    for (int i = 0; i < 12; i++) begin
`ifdef CACHELINE_WRITE_EN
      if ($urandom_range(0, 1) == 1)
        do_write($urandom, rand_line(), rand_gaps(), 1'b0);
      else
        do_read($urandom, rand_line(), rand_gaps(), 1'b0);
`else
      do_read($urandom, rand_line(), rand_gaps(), 1'b0);
`endif
      idle($urandom_range(1, 3), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
